// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-field layout,
// ResultSrc encodings and the access FSM state encoding.
package memory_access_stage_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam int CTL_REG_WRITE = 3;
  localparam int CTL_RES_HI    = 2;
  localparam int CTL_RES_LO    = 1;
  localparam int CTL_MEM_WRITE = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/memory_access_stage_mem_wb.sv
// MEM/WB pipeline register; loads every cycle, either the MEM-stage
// results or an all-zero bubble.
module mem_wb_register (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        bubble,
  input  logic [31:0] alu_result,
  input  logic [31:0] read_data,
  input  logic [31:0] pc_plus4,
  input  logic [4:0]  rd,
  input  logic [2:0]  control,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [31:0] pc_plus4_w,
  output logic [4:0]  rd_w,
  output logic [2:0]  control_w
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
      control_w    <= '0;
    end else if (bubble) begin
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
      control_w    <= '0;
    end else begin
      alu_result_w <= alu_result;
      read_data_w  <= read_data;
      pc_plus4_w   <= pc_plus4;
      rd_w         <= rd;
      control_w    <= control;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage of the RV32I pipeline: req/ready data-memory handshake with
// wait states and a bounded timeout, stall generation and forwarding taps.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic [3:0]  controlM,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        StallM,
  output logic [31:0] ALUResultMH,
  output logic [4:0]  RdMH,
  output logic        RegWriteMH,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic [2:0]  controlW,
  output logic        BusErrM
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic        bus_err;
  logic        acc, is_load, timeout;
  logic        req_raw, stall_raw, bubble, set_err;
  logic [31:0] read_data;

  assign is_load = (controlM[CTL_RES_HI:CTL_RES_LO] == RES_MEM) && !controlM[CTL_MEM_WRITE];
  assign acc     = controlM[CTL_MEM_WRITE] || (controlM[CTL_RES_HI:CTL_RES_LO] == RES_MEM);
  assign timeout = (state == ST_WAIT) && !dmem_ready && (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (set_err) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    case (state)
      ST_IDLE: begin
        if (acc && !dmem_ready) begin
          state_next    = ST_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      ST_WAIT: begin
        if (dmem_ready || timeout) begin
          state_next = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Ready has priority over timeout, so a late completion never flags an error.
  always_comb begin
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_raw   = acc;
        stall_raw = acc && !dmem_ready;
      end
      ST_WAIT: begin
        req_raw   = 1'b1;
        stall_raw = !dmem_ready && !timeout;
        set_err   = timeout;
      end
      default: ;
    endcase
  end

  assign dmem_req   = RST_N && req_raw;
  assign StallM     = RST_N && stall_raw;
  assign bubble     = stall_raw;
  assign read_data  = (is_load && dmem_ready) ? dmem_rdata : 32'd0;

  assign dmem_we     = controlM[CTL_MEM_WRITE];
  assign dmem_addr   = ALUResultM;
  assign dmem_wdata  = WriteDataM;
  assign ALUResultMH = ALUResultM;
  assign RdMH        = RdM;
  assign RegWriteMH  = controlM[CTL_REG_WRITE];
  assign BusErrM     = bus_err;

  mem_wb_register u_mem_wb (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .bubble       (bubble),
    .alu_result   (ALUResultM),
    .read_data    (read_data),
    .pc_plus4     (PCPlus4M),
    .rd           (RdM),
    .control      (controlM[CTL_REG_WRITE:CTL_RES_LO]),
    .alu_result_w (ALUResultW),
    .read_data_w  (ReadDataW),
    .pc_plus4_w   (PCPlus4W),
    .rd_w         (RdW),
    .control_w    (controlW)
  );

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed corner cases plus randomized
// instructions against a per-instruction latency/result model.
module tb_memory_access_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_rdata;
  logic [4:0]  RdM;
  logic [3:0]  controlM;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, StallM, RegWriteMH, BusErrM;
  logic [31:0] dmem_addr, dmem_wdata, ALUResultMH, ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdMH, RdW;
  logic [2:0]  controlW;

  int total = 0;
  int bad   = 0;
  bit model_err = 1'b0;

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .controlM(controlM),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .StallM(StallM), .ALUResultMH(ALUResultMH), .RdMH(RdMH), .RegWriteMH(RegWriteMH),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .controlW(controlW), .BusErrM(BusErrM)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, "_aluw"}, ALUResultW, 32'd0);
    chk({tag, "_rdataw"}, ReadDataW, 32'd0);
    chk({tag, "_pc4w"}, PCPlus4W, 32'd0);
    chk({tag, "_rdw"}, {27'd0, RdW}, 32'd0);
    chk({tag, "_ctlw"}, {29'd0, controlW}, 32'd0);
    chk({tag, "_buserr"}, {31'd0, BusErrM}, 32'd0);
  endtask

  // One instruction held in EX/MEM; memory is not ready for k cycles.
  // Completion happens after min(k, TO) stall cycles; k > TO means timeout.
  task automatic run_instr(input logic [3:0] ctl, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc4, input logic [4:0] rd, input int k,
                           input logic [31:0] rdv);
    bit          acc, is_load, tmo;
    int          c;
    logic [31:0] rdata_c;
    acc     = ctl[0] || (ctl[2:1] == 2'b01);
    is_load = !ctl[0] && (ctl[2:1] == 2'b01);
    c       = acc ? ((k < TO) ? k : TO) : 0;
    tmo     = acc && (k > TO);
    rdata_c = 32'd0;
    controlM = ctl; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
    for (int i = 0; i <= c; i++) begin
      dmem_ready = acc ? (i >= k) : 1'($urandom_range(0, 1));
      dmem_rdata = rdv ^ 32'(i);
      rdata_c    = dmem_rdata;
      @(negedge CLK);
      chk("stall", {31'd0, StallM}, {31'd0, (i < c)});
      chk("req", {31'd0, dmem_req}, {31'd0, acc});
      chk("we", {31'd0, dmem_we}, {31'd0, ctl[0]});
      chk("addr", dmem_addr, alu);
      chk("wdata", dmem_wdata, wd);
      chk("fwd_alu", ALUResultMH, alu);
      chk("fwd_rd", {27'd0, RdMH}, {27'd0, rd});
      chk("fwd_rw", {31'd0, RegWriteMH}, {31'd0, ctl[3]});
      @(posedge CLK); #1;
      if (i < c) begin
        chk("bubble_ctl", {29'd0, controlW}, 32'd0);
      end else begin
        if (tmo) model_err = 1'b1;
        chk("cap_alu", ALUResultW, alu);
        chk("cap_pc4", PCPlus4W, pc4);
        chk("cap_rd", {27'd0, RdW}, {27'd0, rd});
        chk("cap_ctl", {29'd0, controlW}, {29'd0, ctl[3:1]});
        chk("cap_rdata", ReadDataW, (is_load && !tmo) ? rdata_c : 32'd0);
      end
      chk("buserr", {31'd0, BusErrM}, {31'd0, model_err});
    end
  endtask

  logic [3:0] ctl_tab [5];

  initial begin
    ctl_tab[0] = 4'b1000; ctl_tab[1] = 4'b1010; ctl_tab[2] = 4'b1100;
    ctl_tab[3] = 4'b0001; ctl_tab[4] = 4'b0000;
    RST_N = 1'b0; controlM = 4'b0; ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    #12;
    chk_w_zero("reset");
    chk("reset_req", {31'd0, dmem_req}, 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    run_instr(4'b1010, 32'h100, 32'h0, 32'h204, 5'd7, 0, 32'hDEADBEEF);
    run_instr(4'b0001, 32'h180, 32'hCAFE0001, 32'h208, 5'd0, 3, 32'h12345678);
    run_instr(4'b1000, 32'h55, 32'h0, 32'h20C, 5'd9, 0, 32'h0);
    run_instr(4'b1010, 32'h104, 32'h0, 32'h210, 5'd3, TO, 32'hA5A5A5A5);
    run_instr(4'b1010, 32'h108, 32'h0, 32'h214, 5'd4, TO + 5, 32'h5A5A5A5A);
    run_instr(4'b1100, 32'h10, 32'h0, 32'h218, 5'd1, 0, 32'h0);

    // Reset asserted while a load is waiting.
    controlM = 4'b1010; ALUResultM = 32'h300; RdM = 5'd12; dmem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("rstwait_req", {31'd0, dmem_req}, 32'd0);
    chk("rstwait_stall", {31'd0, StallM}, 32'd0);
    chk_w_zero("rstwait");
    model_err = 1'b0;
    controlM = 4'b0000;
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int n = 0; n < 60; n++) begin
      run_instr(ctl_tab[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), int'($urandom_range(0, TO + 2)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
